// File: rtl/alu_uart_ctrl.sv
// Byte-command controller: builds ALU operands from UART nibbles, launches the
// sequential ALU and returns the result and status bytes over a ready/valid TX port.
module alu_uart_ctrl #(
    parameter int DATA_WIDTH  = 17,
    parameter int ALU_TIMEOUT = 0,
    parameter int AUTO_STATUS = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [1:0]            o_op,
    output logic                  o_start,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic                  i_ovf,
    input  logic                  i_zero,
    input  logic                  i_accept
);

    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int TW     = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((ALU_TIMEOUT > 0) ? ALU_TIMEOUT - 1 : 0);
    localparam logic [1:0]    LAST_BYTE = 2'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ALU, TX_DATA, TX_STATUS} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   r;
    logic                    ovf, zero, err, tmo;
    logic [1:0]              byte_cnt;
    logic [TW-1:0]           wait_cnt;

    logic [3:0]              opcode, nibble;
    logic [NBYTES*8-1:0]     r_ext;
    logic                    tx_fire, timeout, alu_done;
    logic                    err_n, tmo_n, ovf_n, zero_n;
    logic [7:0]              status_n;
    logic [1:0]              next_byte;

    assign opcode    = i_rx_data[3:0];
    assign nibble    = i_rx_data[7:4];
    assign r_ext     = (NBYTES*8)'(r);
    assign tx_fire   = o_tx_valid & i_tx_ready;
    assign next_byte = byte_cnt + 2'd1;

    // The wait counter counts cycles already spent in WAIT_ALU, so the abort
    // fires in the ALU_TIMEOUT-th cycle; a simultaneous accept takes priority.
    assign timeout  = (ALU_TIMEOUT > 0) && (wait_cnt == TMO_LAST) && !i_accept;
    assign alu_done = (state == WAIT_ALU) && (i_accept || timeout);

    // Next flag values; the status byte is snapshotted from these so an
    // auto-sent status already reflects the completion that triggered it.
    always_comb begin
        err_n  = err;
        tmo_n  = tmo;
        ovf_n  = ovf;
        zero_n = zero;
        if (state == TX_STATUS && tx_fire) begin
            err_n = 1'b0;
            tmo_n = 1'b0;
        end
        if (i_rx_valid && (state != IDLE || opcode >= 4'h9))
            err_n = 1'b1;
        if (state == WAIT_ALU) begin
            if (i_accept) begin
                ovf_n  = i_ovf;
                zero_n = i_zero;
            end else if (timeout) begin
                tmo_n = 1'b1;
            end
        end
        status_n = {4'b0, err_n, tmo_n, ovf_n, zero_n};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            r          <= '0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            err        <= 1'b0;
            tmo        <= 1'b0;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_a        <= '0;
            o_b        <= '0;
            o_op       <= '0;
            o_start    <= 1'b0;
        end else begin
            o_start <= 1'b0;
            err     <= err_n;
            tmo     <= tmo_n;
            ovf     <= ovf_n;
            zero    <= zero_n;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (opcode)
                            4'h0: o_a <= {o_a[DATA_WIDTH-5:0], nibble};
                            4'h1: o_b <= {o_b[DATA_WIDTH-5:0], nibble};
                            4'h2: begin
                                state      <= TX_DATA;
                                byte_cnt   <= '0;
                                o_tx_valid <= 1'b1;
                                o_tx_data  <= r_ext[7:0];
                            end
                            4'h3: begin
                                state      <= TX_STATUS;
                                o_tx_valid <= 1'b1;
                                o_tx_data  <= status_n;
                            end
                            4'h4, 4'h5, 4'h6, 4'h7: begin
                                state    <= WAIT_ALU;
                                o_op     <= opcode[1:0];
                                o_start  <= 1'b1;
                                wait_cnt <= '0;
                            end
                            4'h8: begin
                                o_a <= '0;
                                o_b <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_ALU: begin
                    if (i_accept)
                        r <= i_q;
                    if (alu_done) begin
                        if (AUTO_STATUS != 0) begin
                            state      <= TX_STATUS;
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= status_n;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_fire) begin
                        if (byte_cnt == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            byte_cnt  <= next_byte;
                            o_tx_data <= r_ext[{next_byte, 3'b000} +: 8];
                        end
                    end
                end
                TX_STATUS: begin
                    if (tx_fire) begin
                        o_tx_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl (DATA_WIDTH=17, ALU_TIMEOUT=16, AUTO_STATUS=1):
// stimulus pushes expected TX bytes, a negedge monitor pops and compares each transfer.
module tb_alu_uart_ctrl;

    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic [DW-1:0] a, b;
    logic [1:0]    op;
    logic          start;
    logic [DW-1:0] q = '0;
    logic          ovf = 1'b0;
    logic          zero = 1'b0;
    logic          accept = 1'b0;

    int            total = 0;
    int            bad = 0;
    logic [7:0]    exp_q[$];
    logic          held = 1'b0;
    logic [7:0]    held_data = '0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(.DATA_WIDTH(DW), .ALU_TIMEOUT(16), .AUTO_STATUS(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_a(a), .o_b(b), .o_op(op), .o_start(start),
        .i_q(q), .i_ovf(ovf), .i_zero(zero), .i_accept(accept)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        tick();
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic alu_reply(input logic [DW-1:0] qv, input logic ov, input logic zr);
        q      = qv;
        ovf    = ov;
        zero   = zr;
        accept = 1'b1;
        tick();
        accept = 1'b0;
    endtask

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
    endtask

    // Bounded drain: every expected byte transferred and the TX port idle again.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !tx_valid) break;
            tick();
        end
        chk(name, {31'b0, (exp_q.size() != 0) || tx_valid}, 32'h0);
    endtask

    // Monitor: checks hold stability under back-pressure and scores each transfer.
    initial begin
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                if (held) chk("tx_hold", tx_data, held_data);
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: got 0x%0h, want no byte", tx_data);
                    end else begin
                        want = exp_q.pop_front();
                        chk("tx_byte", tx_data, want);
                    end
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = tx_data;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_op", op, 0);
        chk("rst_start", start, 0);
        rst = 1'b0;
        tick();

        // Operand assembly and truncation
        send_rx(8'h10);
        chk("load_a1", a, 17'h00001);
        send_rx(8'h20);
        send_rx(8'h30);
        send_rx(8'h40);
        send_rx(8'h50);
        chk("load_a5", a, 17'h12345);
        send_rx(8'h60);
        chk("load_trunc", a, 17'h03456);

        // Illegal opcode sets err, status read clears it
        send_rx(8'h0F);
        exp_q.push_back(8'h08);
        send_rx(8'h03);
        wait_idle("drain_err");
        exp_q.push_back(8'h00);
        send_rx(8'h03);
        wait_idle("drain_err_clr");

        // Add 3+5 with TX back-pressure
        send_rx(8'h08);
        chk("clr_a", a, 0);
        chk("clr_b", b, 0);
        send_rx(8'h30);
        send_rx(8'h51);
        chk("a3", a, 3);
        chk("b5", b, 5);
        send_rx(8'h44);
        chk("add_start", start, 1);
        chk("add_op", op, 0);
        tick();
        chk("start_pulse", start, 0);
        exp_q.push_back(8'h00);
        alu_reply(17'd8, 1'b0, 1'b0);
        wait_idle("drain_add_status");
        tx_ready = 1'b0;
        push3(8'h08, 8'h00, 8'h00);
        send_rx(8'h02);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", tx_valid, 1);
            chk("bp_data", tx_data, 8'h08);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle("drain_bp");

        // Zero flag, persistent across status reads
        send_rx(8'h08);
        send_rx(8'h70);
        send_rx(8'h71);
        exp_q.push_back(8'h01);
        send_rx(8'h54);
        chk("flag_op", op, 0);
        alu_reply(17'd0, 1'b0, 1'b1);
        wait_idle("drain_flag_auto");
        exp_q.push_back(8'h01);
        send_rx(8'h03);
        wait_idle("drain_flag1");
        exp_q.push_back(8'h01);
        send_rx(8'h03);
        wait_idle("drain_flag2");

        // Command dropped during WAIT_ALU
        send_rx(8'h06);
        chk("mul_start", start, 1);
        chk("mul_op", op, 2);
        send_rx(8'h10);
        chk("drop_a", a, 7);
        exp_q.push_back(8'h08);
        alu_reply(17'h31, 1'b0, 1'b0);
        wait_idle("drain_drop_auto");
        exp_q.push_back(8'h00);
        send_rx(8'h03);
        wait_idle("drain_drop_clr");

        // Best-case readout latency: NBYTES+1 cycles to IDLE
        push3(8'h31, 8'h00, 8'h00);
        send_rx(8'h02);
        chk("rd_c1", tx_valid, 1);
        tick();
        tick();
        chk("rd_c3", tx_valid, 1);
        tick();
        chk("rd_c4", tx_valid, 0);
        wait_idle("drain_rd");

        // Timeout: exit exactly 16 cycles after o_start, R kept
        exp_q.push_back(8'h04);
        tx_ready = 1'b0;
        send_rx(8'h64);
        repeat (15) tick();
        chk("tmo_early", tx_valid, 0);
        tick();
        chk("tmo_exit", tx_valid, 1);
        tx_ready = 1'b1;
        wait_idle("drain_tmo");
        push3(8'h31, 8'h00, 8'h00);
        send_rx(8'h02);
        wait_idle("drain_tmo_r");
        exp_q.push_back(8'h00);
        send_rx(8'h03);
        wait_idle("drain_tmo_clr");

        // Accept in the 16th cycle beats the timeout
        send_rx(8'h64);
        repeat (15) tick();
        exp_q.push_back(8'h02);
        alu_reply(17'h55, 1'b1, 1'b0);
        wait_idle("drain_race");
        push3(8'h55, 8'h00, 8'h00);
        send_rx(8'h02);
        wait_idle("drain_race_r");

        // Reset while the second result byte is offered
        send_rx(8'h10);
        exp_q.push_back(8'h55);
        send_rx(8'h02);
        tick();
        chk("burst_valid", tx_valid, 1);
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mrst_tx_valid", tx_valid, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_a", a, 0);
        chk("mrst_b", b, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        push3(8'h00, 8'h00, 8'h00);
        send_rx(8'h02);
        wait_idle("drain_mrst_r");
        exp_q.push_back(8'h00);
        send_rx(8'h03);
        wait_idle("drain_mrst_s");

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
